action_animator: RTL and testbench
==================================

# action_animator

Downstream consumer of the gameboy controller FSM's 3-bit action code `z`. It detects each new action the controller issues and plays it as a fixed-length sprite animation: a frame index advanced on an internal tick. When no action is playing, it loops the Run animation. Its outputs drive the sprite/renderer stage.

## Interface
- `TICK_DIV`, default 4: clock cycles per animation frame; must be ≥1.
- `FRAMES`, default 4: frames per action animation; power of 2, ≥2.
- `QDEPTH`, default 4: pending-action queue depth; power of 2. Used only when `ACTION_QUEUE_EN` is defined.
- `clock`  in  1: clock.
- `reset`  in  1: reset, synchronous, active-high.
- `action_in`  in  3: action code from the controller.
  - Kick=0, Punch=1, Jump=2, Duck=3, Run=4.
  - Codes 5–7 are illegal.
- `sprite_action`  out  3: action currently animated.
- `frame_idx`  out  $clog2(FRAMES): current frame of the animation.
- `busy`  out  1: high while a non-Run action is playing.
- `dropped`  out  1: one-cycle pulse when a request is discarded.
- `q_count`  out  $clog2(QDEPTH)+1: number of queued actions. Always 0 without the macro.

## Operation
- **Input tracking.** `prev_q` registers `action_in` every cycle. Reset value is Run.
- **Request.** `req = (action_in != prev_q) && action_in <= 3`.
  - Run (4) and illegal codes (5–7) never request.
  - Holding one code constant produces exactly one request.
- **Tick.** `tick_cnt` counts 0..TICK_DIV-1. A frame ends when `tick_cnt == TICK_DIV-1`, and `frame_idx` then increments modulo FRAMES.
- **State IDLE.**
  - `sprite_action` = Run, `busy` = 0.
  - `frame_idx` loops continuously on the tick.
  - On `req`: go to PLAY. Load `cur` = `action_in`, clear `frame_idx` and `tick_cnt`.
- **State PLAY.**
  - `sprite_action` = `cur`, `busy` = 1.
  - "Last cycle" means `frame_idx == FRAMES-1` and `tick_cnt == TICK_DIV-1`.
  - On the last cycle the next action is chosen by priority:
    1. Queue non-empty: pop the head into `cur`.
    2. Otherwise, `req` present: load `action_in` directly.
    3. Otherwise: go to IDLE.
  - In cases 1 and 2, restart at frame 0 with `tick_cnt` = 0 and no gap cycle.
- **Request during PLAY (not taken by the last-cycle rule).**
  - Enqueue if the queue is not full.
  - Otherwise pulse `dropped` on the following cycle.
- **Simultaneous push and pop.** Both happen in the same cycle and `q_count` is unchanged. A push into a full queue succeeds if a pop occurs that same cycle.
- **Reset values.** `sprite_action` = 4, `frame_idx` = 0, `busy` = 0, `dropped` = 0, `q_count` = 0. The queue is flushed and the state is IDLE.
- **Reset mid-operation.** Abandons the current action and all queued actions, with no `dropped` pulse.

## Timing
- **Latency.** If `action_in` changes before edge N (IDLE, `req` high), `sprite_action` shows the new action after edge N. Input to output is 1 cycle.
- **Duration.** Each action occupies exactly `FRAMES*TICK_DIV` cycles; `busy` stays high for that whole span.
- **Back-to-back actions.** `busy` stays high continuously, and `frame_idx` goes from FRAMES-1 to 0 on the boundary edge.
- **Output registers.** All outputs are registered; there are no combinational paths from `action_in`.
- **Queue boundaries.** `q_count` updates on the edge of the push or pop. Full is `q_count == QDEPTH`; empty is `q_count == 0`.

## Configuration
- **`ACTION_QUEUE_EN` defined:** the QDEPTH-entry FIFO is instantiated and queues requests as described above.
- **`ACTION_QUEUE_EN` undefined:**
  - No FIFO; `q_count` is tied to 0.
  - Any request during PLAY, other than one on the last cycle, pulses `dropped`.

## Structure
- **Shared package `gameboy_pkg`:**
  - Action codes KICK..RUN and the button codes Fight=0, React=1, A=2, B=3, used by both the controller and this block.
  - Animator state enum IDLE/PLAY.
- **Sub-module `action_fifo`:** synchronous 3-bit-wide FIFO, instantiated only under the macro.
  - Parameter: depth.
  - Ports: push, pop, din, dout, count, full, empty.
  - Supports simultaneous push and pop.

## Test plan
All scenarios use TICK_DIV=4, FRAMES=4, QDEPTH=4, so one action lasts 16 cycles.
- **Reset and idle loop.** Assert reset, then release with `action_in`=4 → `sprite_action`=4, `busy`=0, and `frame_idx` follows 0,0,0,0,1,1,1,1,2,… wrapping after 3.
- **Single action.** `action_in` goes 4→0 before edge 10 → `sprite_action`=0 and `frame_idx`=0 after edge 10, `busy` high for 16 cycles, then `sprite_action`=4.
- **Input filtering.** Hold `action_in`=1 for 40 cycles → exactly one 16-cycle Punch. Setting `action_in`=6 → no change and no `dropped` pulse.
- **Queued sequence (macro on).** Kick, then Punch at cycle +3, then Jump at cycle +6 → Kick, Punch, Jump play back-to-back. `q_count` peaks at 2, `busy` stays high for 48 cycles, and `dropped` never pulses.
- **Overflow.** Macro on: 5 distinct changes during one action → `q_count`=4 and a single `dropped` pulse for the 5th. Macro off: a 2nd request at cycle +3 → `dropped` pulse and only the first action plays.
- **Reset mid-PLAY.** Reset at frame 2 with 2 actions queued → after the next edge `busy`=0, `sprite_action`=4, `q_count`=0, and no queued action ever plays.

Source files
------------

// File: rtl/gameboy_pkg.sv
// Shared gameboy codes: controller action/button encodings
// and the action animator state enum.
package gameboy_pkg;

  typedef enum logic [2:0] {
    KICK  = 3'd0,
    PUNCH = 3'd1,
    JUMP  = 3'd2,
    DUCK  = 3'd3,
    RUN   = 3'd4
  } action_e;

  typedef enum logic [1:0] {
    BTN_FIGHT = 2'd0,
    BTN_REACT = 2'd1,
    BTN_A     = 2'd2,
    BTN_B     = 2'd3
  } button_e;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } anim_state_e;

endpackage

// File: rtl/action_fifo.sv
// Pending-action FIFO, 3 bits wide, DEPTH entries.
// Simultaneous push and pop keep the count unchanged.
module action_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [2:0]               din,
  output logic [2:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [2:0]             r_mem [DEPTH];
  logic [AW-1:0]          r_wr;
  logic [AW-1:0]          r_rd;
  logic [$clog2(DEPTH):0] r_cnt;

  always_ff @(posedge clock) begin
    if (push) r_mem[r_wr] <= din;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (push) r_wr <= r_wr + 1'b1;
      if (pop)  r_rd <= r_rd + 1'b1;
      unique case ({push, pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign dout  = r_mem[r_rd];
  assign count = r_cnt;
  assign full  = (r_cnt == ($clog2(DEPTH)+1)'(DEPTH));
  assign empty = (r_cnt == '0);

endmodule

// File: rtl/action_animator.sv
// Plays controller actions as fixed-length sprite animations.
// ACTION_QUEUE_EN adds a FIFO for requests arriving mid-play.
import gameboy_pkg::*;

module action_animator #(
  parameter int TICK_DIV = 4,
  parameter int FRAMES   = 4,
  parameter int QDEPTH   = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [2:0]                action_in,
  output logic [2:0]                sprite_action,
  output logic [$clog2(FRAMES)-1:0] frame_idx,
  output logic                      busy,
  output logic                      dropped,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int FW = $clog2(FRAMES);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TICK_DIV - 1);
  localparam logic [FW-1:0] FLAST = FW'(FRAMES - 1);

  anim_state_e   r_state;
  logic [2:0]    r_prev;
  logic [2:0]    r_cur;
  logic [FW-1:0] r_frame;
  logic [TW-1:0] r_tick;
  logic          r_busy;
  logic          r_drop;

  logic       w_req;
  logic       w_play;
  logic       w_tend;
  logic       w_last;
  logic       w_direct;
  logic       w_enq;
  logic       w_drop;
  logic       w_empty;
  logic [2:0] w_head;

  assign w_req    = (action_in != r_prev) && (action_in <= DUCK);
  assign w_play   = (r_state == PLAY);
  assign w_tend   = (r_tick == TLAST);
  assign w_last   = w_play && w_tend && (r_frame == FLAST);
  assign w_direct = w_last && w_empty && w_req;
  assign w_drop   = w_play && w_req && !w_direct && !w_enq;

`ifdef ACTION_QUEUE_EN
  logic w_pop;
  logic w_full;

  // a full queue still accepts when its head leaves this cycle
  assign w_pop = w_last && !w_empty;
  assign w_enq = w_play && w_req && !w_direct
              && (!w_full || w_pop);

  action_fifo #(
    .DEPTH(QDEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_enq),
    .pop   (w_pop),
    .din   (action_in),
    .dout  (w_head),
    .count (q_count),
    .full  (w_full),
    .empty (w_empty)
  );
`else
  assign w_enq   = 1'b0;
  assign w_empty = 1'b1;
  assign w_head  = RUN;
  assign q_count = '0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_prev  <= RUN;
      r_cur   <= RUN;
      r_frame <= '0;
      r_tick  <= '0;
      r_busy  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_prev <= action_in;
      r_drop <= w_drop;
      r_tick <= w_tend ? '0 : r_tick + 1'b1;
      if (w_tend) r_frame <= r_frame + 1'b1;
      unique case (r_state)
        IDLE: begin
          if (w_req) begin
            r_state <= PLAY;
            r_cur   <= action_in;
            r_busy  <= 1'b1;
            r_frame <= '0;
            r_tick  <= '0;
          end
        end
        PLAY: begin
          if (w_last) begin
            if (!w_empty) begin
              r_cur <= w_head;
            end else if (w_req) begin
              r_cur <= action_in;
            end else begin
              r_state <= IDLE;
              r_cur   <= RUN;
              r_busy  <= 1'b0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sprite_action = r_cur;
  assign frame_idx     = r_frame;
  assign busy          = r_busy;
  assign dropped       = r_drop;

endmodule

// File: tb/tb_action_animator.sv
// Random and directed stimulus against a cycle-count
// reference model of the action animator.
module tb_action_animator;

  localparam int TD = 4;
  localparam int FR = 4;
  localparam int QD = 4;

  logic       clock;
  logic       reset;
  logic [2:0] action_in;
  logic [2:0] sprite_action;
  logic [1:0] frame_idx;
  logic       busy;
  logic       dropped;
  logic [2:0] q_count;

  int n_chk;
  int n_fail;

  bit m_play;
  int m_cur;
  int m_el;
  int m_prev;
  bit m_drop;
  int mq[$];

  logic [2:0] a;

  action_animator #(
    .TICK_DIV(TD),
    .FRAMES  (FR),
    .QDEPTH  (QD)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .action_in    (action_in),
    .sprite_action(sprite_action),
    .frame_idx    (frame_idx),
    .busy         (busy),
    .dropped      (dropped),
    .q_count      (q_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got,
                     input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d",
               tag, $time, got, exp);
    end
  endtask

  // m_el = cycles elapsed in the current animation or idle loop
  task automatic model(input int av, input bit rst);
    bit req;
    bit taken;
    if (rst) begin
      m_play = 0;
      m_cur  = 4;
      m_el   = 0;
      m_prev = 4;
      m_drop = 0;
      mq.delete();
      return;
    end
    req    = (av != m_prev) && (av <= 3);
    m_prev = av;
    m_drop = 0;
    taken  = 0;
    if (!m_play) begin
      if (req) begin
        m_play = 1;
        m_cur  = av;
        m_el   = 0;
      end else begin
        m_el++;
      end
    end else begin
      if (m_el == FR*TD-1) begin
        m_el = 0;
        if (mq.size() > 0) begin
          m_cur = mq.pop_front();
        end else if (req) begin
          m_cur = av;
          taken = 1;
        end else begin
          m_play = 0;
          m_cur  = 4;
        end
      end else begin
        m_el++;
      end
      if (req && !taken) begin
`ifdef ACTION_QUEUE_EN
        if (mq.size() < QD) mq.push_back(av);
        else m_drop = 1;
`else
        m_drop = 1;
`endif
      end
    end
  endtask

  task automatic step(input logic [2:0] av, input bit rst);
    action_in = av;
    reset     = rst;
    @(posedge clock);
    model(int'(av), rst);
    #1;
    chk("sprite", int'(sprite_action), m_cur);
    chk("frame", int'(frame_idx), (m_el / TD) % FR);
    chk("busy", int'(busy), int'(m_play));
    chk("dropped", int'(dropped), int'(m_drop));
    chk("q_count", int'(q_count), mq.size());
  endtask

  task automatic hold(input logic [2:0] av, input int n);
    for (int i = 0; i < n; i++) step(av, 1'b0);
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    action_in = 3'd4;
    reset     = 1'b1;
    repeat (3) step(3'd4, 1'b1);
    chk("rst_sprite", int'(sprite_action), 4);
    chk("rst_busy", int'(busy), 0);
    hold(3'd4, 14);
    hold(3'd0, 20);
    hold(3'd4, 10);
    hold(3'd1, 40);
    hold(3'd6, 10);
    hold(3'd4, 5);
    hold(3'd0, 3);
    hold(3'd1, 3);
    hold(3'd2, 60);
    hold(3'd4, 5);
    hold(3'd0, 1);
    hold(3'd1, 1);
    hold(3'd2, 1);
    hold(3'd3, 1);
    hold(3'd0, 1);
    hold(3'd1, 1);
    hold(3'd4, 100);
    hold(3'd0, 1);
    hold(3'd1, 1);
    hold(3'd2, 7);
    step(3'd2, 1'b1);
    chk("rst_mid_q", int'(q_count), 0);
    chk("rst_mid_busy", int'(busy), 0);
    hold(3'd4, 40);
    a = 3'd4;
    repeat (3000) begin
      if ($urandom_range(0, 5) == 0)
        a = 3'($urandom_range(0, 7));
      step(a, $urandom_range(0, 399) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
